router_rx_port: RTL and testbench
=================================

ROUTER_RX_PORT -- requirements
Module: router_rx_port

Interface
REQ-001 SHALL have parameter PORT_ADDR, default 2'd0, the router output port this instance drains (0..2).
REQ-002 SHALL have parameter READ_DELAY, default 5, the cycles from vld_out rising to the first read_enb (legal 0..25, below the router's 30-cycle soft-reset window).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 vld_out  input  1  router port FIFO non-empty.
REQ-006 data_in  input  8  router port data_out; valid the cycle after read_enb was high (1-cycle FIFO read latency).
REQ-007 read_enb  output  1  read strobe to the router port FIFO.
REQ-008 pkt_data  output  8  received byte (header, payload or parity).
REQ-009 pkt_valid  output  1  pkt_data valid, one cycle per byte.
REQ-010 pkt_sop  output  1  with pkt_valid on the header byte.
REQ-011 pkt_eop  output  1  with pkt_valid on the parity byte.
REQ-012 parity_err  output  1  with pkt_eop; received parity != computed parity.
REQ-013 addr_err  output  1  with pkt_eop; header[1:0] != PORT_ADDR.
REQ-014 pkt_count  output  16  packets completed since reset, wraps 16'hFFFF->0.
REQ-015 err_count  output  16  packets with parity_err or addr_err, wraps.

Function
REQ-016 Packet format: header {len[7:2], addr[1:0]}, len payload bytes (0..63), one parity byte = XOR of header and all payload bytes; total T = len+2 bytes.
REQ-017 FSM states IDLE, WAIT, READ, DONE; reset state IDLE.
REQ-018 IDLE->WAIT when vld_out=1; the delay counter loads 0.
REQ-019 WAIT: counter increments each cycle; ->READ when counter==READ_DELAY (READ_DELAY=0: READ the cycle after vld_out seen).
REQ-020 READ: read_enb = vld_out AND (rd_cnt < 2 before the header is known, else rd_cnt < T); rd_cnt counts issued reads, cleared on entry to READ.
REQ-021 The header is known from the cycle it arrives on data_in (T used combinationally that cycle, then registered).
REQ-022 vld_out low mid-packet pauses read_enb without leaving READ; reading resumes when vld_out returns.
REQ-023 Each byte is sampled from data_in the cycle after its read_enb; the byte index increments per sample.
REQ-024 pkt_data/pkt_valid/pkt_sop/pkt_eop are registered: asserted the cycle after the byte is sampled.
REQ-025 Running XOR covers header and payload; parity_err and addr_err are evaluated on the parity byte and are low on all other cycles.
REQ-026 READ->DONE when the T-th byte is sampled; DONE lasts one cycle and updates pkt_count (+1) and err_count (+1 if either error).
REQ-027 DONE->IDLE; a back-to-back packet with vld_out already high re-enters WAIT the next cycle.
REQ-028 read_enb is never high in IDLE, WAIT or DONE; at most T reads are issued per packet.

Reset
REQ-029 rst asserted: state IDLE; read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, parity_err, addr_err = 0; pkt_count and err_count = 0; all counters and the XOR accumulator = 0; this applies immediately and asynchronously.
REQ-030 rst mid-packet: the partial packet is discarded, no pkt_eop, and counts are cleared; after release the next vld_out starts a fresh packet.

Verification
REQ-031 PORT_ADDR=1, READ_DELAY=5, header 8'h0D (len 3, addr 1), payload 11,22,33, parity 8'h0D^8'h11^8'h22^8'h33 -> read_enb high for 5 cycles starting 6 cycles after vld_out rises; pkt_sop on 0D, pkt_eop on parity, parity_err=0, addr_err=0, pkt_count=1.
REQ-032 Same packet with parity byte XOR 8'h01 -> parity_err=1 on eop, err_count=1.
REQ-033 Header 8'h02 (len 0, addr 2) to PORT_ADDR=0 -> exactly 2 reads, addr_err=1, pkt_count=1.
REQ-034 vld_out dropped for 3 cycles after payload byte 2 of a len-10 packet -> read_enb low for those cycles, 12 bytes delivered in order, no extra reads.
REQ-035 Two back-to-back len-63 packets, then rst pulsed during a third -> pkt_count=2 before reset, all outputs 0 at reset, no pkt_eop for the third packet.
REQ-036 READ_DELAY=0 and READ_DELAY=25 -> first read_enb 1 and 26 cycles after vld_out rises, respectively.

Source files
------------

// File: rtl/router_rx_port.sv
// Receive side of one router output port. It waits READ_DELAY cycles after the port
// FIFO goes non-empty, then drains one packet and checks its parity and address.
module router_rx_port #(
  parameter logic [1:0] PORT_ADDR  = 2'd0,
  parameter int         READ_DELAY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_out,
  input  logic [7:0]  data_in,
  output logic        read_enb,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic        parity_err,
  output logic        addr_err,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [4:0] DLY    = 5'(READ_DELAY);

  logic [1:0] r_state;
  logic [4:0] r_dly;
  logic [6:0] r_rd_cnt, r_idx, r_tot;
  logic       r_hdr_known, r_rd_d;
  logic [7:0] r_xor;
  logic [1:0] r_addr;

  logic       w_samp, w_hdr_now, w_known, w_last, w_rd;
  logic [6:0] w_tot, w_lim;

  // The FIFO returns a byte one cycle after its strobe, so the strobe delayed marks a sample.
  assign w_samp    = r_rd_d;
  assign w_hdr_now = w_samp && (r_idx == 7'd0);
  assign w_tot     = w_hdr_now ? ({1'b0, data_in[7:2]} + 7'd2) : r_tot;
  assign w_known   = r_hdr_known || w_hdr_now;
  // Until the header is in hand only header + one more byte can be safely requested.
  assign w_lim     = w_known ? w_tot : 7'd2;
  assign w_rd      = (r_state == S_READ) && vld_out && (r_rd_cnt < w_lim);
  assign w_last    = w_samp && w_known && (r_idx == (w_tot - 7'd1));
  assign read_enb  = w_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dly       <= '0;
      r_rd_cnt    <= '0;
      r_idx       <= '0;
      r_tot       <= '0;
      r_hdr_known <= 1'b0;
      r_rd_d      <= 1'b0;
      r_xor       <= '0;
      r_addr      <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      pkt_sop     <= 1'b0;
      pkt_eop     <= 1'b0;
      parity_err  <= 1'b0;
      addr_err    <= 1'b0;
      pkt_count   <= '0;
      err_count   <= '0;
    end else begin
      r_rd_d     <= w_rd;
      pkt_valid  <= w_samp;
      pkt_sop    <= w_hdr_now;
      pkt_eop    <= w_last;
      parity_err <= w_last && (data_in != r_xor);
      addr_err   <= w_last && (r_addr != PORT_ADDR);
      if (w_samp) pkt_data <= data_in;
      case (r_state)
        S_IDLE: if (vld_out) begin
          r_state <= S_WAIT;
          r_dly   <= '0;
        end
        S_WAIT: if (r_dly == DLY) begin
          r_state     <= S_READ;
          r_rd_cnt    <= '0;
          r_idx       <= '0;
          r_hdr_known <= 1'b0;
          r_xor       <= '0;
        end else begin
          r_dly <= r_dly + 5'd1;
        end
        S_READ: begin
          if (w_rd) r_rd_cnt <= r_rd_cnt + 7'd1;
          if (w_samp) begin
            r_idx <= r_idx + 7'd1;
            if (!w_last) r_xor <= r_xor ^ data_in;
          end
          if (w_hdr_now) begin
            r_tot       <= w_tot;
            r_hdr_known <= 1'b1;
            r_addr      <= data_in[1:0];
          end
          if (w_last) r_state <= S_DONE;
        end
        default: begin
          // Error flags are registered on the parity byte and are still high here.
          pkt_count <= pkt_count + 16'd1;
          if (parity_err || addr_err) err_count <= err_count + 16'd1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: three instances, each fed by a small FIFO model,
// with a per-instance scoreboard of expected bytes and flags.
module tb_router_rx_port;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       pe;
    logic       ae;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld_out, read_enb, pkt_valid, pkt_sop, pkt_eop, parity_err, addr_err;
  logic [2:0]  pause;
  logic [7:0]  data_in [3];
  logic [7:0]  pkt_data [3];
  logic [15:0] pkt_count [3];
  logic [15:0] err_count [3];

  logic [7:0]  mem [3][256];
  logic [7:0]  wp [3] = '{default: 8'd0};
  logic [7:0]  rp [3] = '{default: 8'd0};
  int          cyc = 0;

  exp_t        sb [3][$];
  int          exp_pc [3], exp_ec [3], t0 [3], lat [3], rdcnt [3], rd_first [3], rd_last [3];
  bit          armed [3];
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign vld_out[g] = (wp[g] != rp[g]) && !pause[g];
    router_rx_port #(
      .PORT_ADDR  ((g == 0) ? 2'd1 : 2'd0),
      .READ_DELAY ((g == 0) ? 5 : (g == 1) ? 0 : 25)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .vld_out    (vld_out[g]),
      .data_in    (data_in[g]),
      .read_enb   (read_enb[g]),
      .pkt_data   (pkt_data[g]),
      .pkt_valid  (pkt_valid[g]),
      .pkt_sop    (pkt_sop[g]),
      .pkt_eop    (pkt_eop[g]),
      .parity_err (parity_err[g]),
      .addr_err   (addr_err[g]),
      .pkt_count  (pkt_count[g]),
      .err_count  (err_count[g])
    );
  end

  // Router port FIFO model: one-cycle read latency, flushed while reset is held.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) rp[i] <= wp[i];
      else if (read_enb[i]) begin
        data_in[i] <= mem[i][rp[i]];
        rp[i]      <= rp[i] + 8'd1;
      end
    end
  end

  function automatic logic [1:0] pa(input int i);
    return (i == 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input int i, input int len, input logic [1:0] addr, input logic [7:0] base,
                      input logic [7:0] flip, input bit cnt);
    logic [7:0] b, x, p;
    logic       ae;
    exp_t       e;
    p  = wp[i];
    ae = (addr != pa(i));
    b  = {6'(len), addr};
    x  = b;
    mem[i][p] = b; p++;
    e = '{d: b, sop: 1'b1, eop: 1'b0, pe: 1'b0, ae: 1'b0};
    sb[i].push_back(e);
    for (int k = 1; k <= len; k++) begin
      b = 8'(int'(base) * k);
      x ^= b;
      mem[i][p] = b; p++;
      e = '{d: b, sop: 1'b0, eop: 1'b0, pe: 1'b0, ae: 1'b0};
      sb[i].push_back(e);
    end
    b = x ^ flip;
    mem[i][p] = b; p++;
    e = '{d: b, sop: 1'b0, eop: 1'b1, pe: (flip != 8'd0), ae: ae};
    sb[i].push_back(e);
    if (cnt) begin
      exp_pc[i]++;
      if (flip != 8'd0 || ae) exp_ec[i]++;
    end
    t0[i]       = cyc + 1;
    armed[i]    = 1'b1;
    rd_first[i] = -1;
    wp[i]       = p;
  endtask

  task automatic wait_pc(input int i);
    int n;
    n = 0;
    while (pkt_count[i] != 16'(exp_pc[i]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_done_in_time", (n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_rst_outs(input int i);
    chk("rst_outputs", {read_enb[i], pkt_data[i], pkt_valid[i], pkt_sop[i], pkt_eop[i],
                        parity_err[i], addr_err[i], pkt_count[i], err_count[i]}, 32'd0);
  endtask

  initial begin
    logic [7:0] b0;
    int         n;
    rst   = 1'b1;
    pause = 3'b000;
    for (int i = 0; i < 3; i++) begin
      exp_pc[i] = 0; exp_ec[i] = 0; lat[i] = -1; rdcnt[i] = 0;
      rd_first[i] = -1; rd_last[i] = -1; armed[i] = 1'b0;
    end

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          #2;
          for (int i = 0; i < 3; i++) begin
            if (!rst) begin
              if (read_enb[i]) begin
                chk("read_nonempty_fifo", (wp[i] != rp[i]), 1);
                rdcnt[i]++;
                if (rd_first[i] < 0) rd_first[i] = cyc;
                rd_last[i] = cyc;
                if (armed[i]) begin
                  lat[i]   = cyc - t0[i];
                  armed[i] = 1'b0;
                end
              end
              if (pkt_valid[i]) begin
                chk("byte_expected", (sb[i].size() != 0), 1);
                if (sb[i].size() != 0)
                  chk($sformatf("byte%0d", i),
                      {pkt_data[i], pkt_sop[i], pkt_eop[i], parity_err[i], addr_err[i]},
                      sb[i].pop_front());
              end else begin
                chk("idle_flags", {pkt_sop[i], pkt_eop[i], parity_err[i], addr_err[i]}, 4'h0);
              end
            end
          end
        end
      end
      begin : watchdog
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_rst_outs(i);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good packet, then the same packet with a corrupted parity byte
    rdcnt[0] = 0;
    send(0, 3, 2'd1, 8'h11, 8'h00, 1'b1);
    wait_pc(0);
    chk("lat_rd5", lat[0], 6);
    chk("reads_pkt1", rdcnt[0], 5);
    chk("reads_contiguous", rd_last[0] - rd_first[0], 4);
    chk("pkt_count_1", pkt_count[0], 1);
    chk("err_count_0", err_count[0], 0);
    send(0, 3, 2'd1, 8'h11, 8'h01, 1'b1);
    wait_pc(0);
    chk("pkt_count_2", pkt_count[0], 2);
    chk("err_count_parity", err_count[0], 1);

    // Zero-length packet with the wrong address, READ_DELAY 0
    rdcnt[1] = 0;
    send(1, 0, 2'd2, 8'h00, 8'h00, 1'b1);
    wait_pc(1);
    chk("reads_len0", rdcnt[1], 2);
    chk("lat_rd0", lat[1], 1);
    chk("pkt_count_len0", pkt_count[1], 1);
    chk("err_count_addr", err_count[1], 1);

    // Longest legal delay
    send(2, 4, 2'd0, 8'h05, 8'h00, 1'b1);
    wait_pc(2);
    chk("lat_rd25", lat[2], 26);
    chk("err_count_rd25", err_count[2], 0);

    // vld_out drops for three cycles after the second payload byte has been read
    rdcnt[0] = 0;
    b0 = rp[0];
    send(0, 10, 2'd1, 8'h07, 8'h00, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (8'(rp[0] - b0) != 8'd3 && n < 500);
    chk("pause_point", 8'(rp[0] - b0), 3);
    pause[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1 chk("pause_no_read", read_enb[0], 0);
      @(negedge clk);
    end
    chk("pause_rp_held", 8'(rp[0] - b0), 3);
    pause[0] = 1'b0;
    wait_pc(0);
    chk("reads_len10", rdcnt[0], 12);
    chk("fifo_drained_len10", 8'(rp[0] - b0), 12);

    // Fresh counts, two back-to-back len-63 packets, reset in the middle of a third
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin exp_pc[i] = 0; exp_ec[i] = 0; sb[i].delete(); end
    @(negedge clk);
    rdcnt[0] = 0;
    send(0, 63, 2'd1, 8'h03, 8'h00, 1'b1);
    send(0, 63, 2'd1, 8'h0B, 8'h00, 1'b1);
    wait_pc(0);
    chk("pkt_count_b2b", pkt_count[0], 2);
    chk("reads_b2b", rdcnt[0], 130);
    chk("sb_empty_b2b", sb[0].size(), 0);
    b0 = rp[0];
    send(0, 63, 2'd1, 8'h0D, 8'h00, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (8'(rp[0] - b0) < 8'd20 && n < 500);
    rst = 1'b1;
    #1 chk_rst_outs(0);
    sb[0].delete();
    exp_pc[0] = 0;
    exp_ec[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("no_eop_after_rst", pkt_count[0], 0);
    send(0, 2, 2'd1, 8'h44, 8'h00, 1'b1);
    wait_pc(0);
    chk("pkt_after_rst", pkt_count[0], 1);
    chk("lat_after_rst", lat[0], 6);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("sb_drained", sb[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
